// File: rtl/mips_alu.sv
// MIPS datapath ALU: combinational result/zero from one shared adder,
// plus an enabled N/Z/C/V flag register cleared by asynchronous reset.
module mips_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    input  logic             flag_en,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SLT  = 3'b011,
        OP_ANDN = 3'b100,
        OP_ORN  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLTU = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    alu_op_e          op;
    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    flags_t           flags_d;
    flags_t           flags_q;

    assign op       = alu_op_e'(ALUControl);
    assign is_sub   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    assign is_arith = is_sub || (op == OP_ADD);

    // Single adder: subtraction and both compares use A + ~B + 1.
    assign b_eff        = is_sub ? ~B : B;
    assign {carry, sum} = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign ovf          = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        // NOTE: default first so no path through the case leaves a latch.
        ALUResult = '0;
        case (op)
            OP_AND:  ALUResult = A & B;
            OP_OR:   ALUResult = A | B;
            OP_ADD:  ALUResult = sum;
            OP_SLT:  ALUResult = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OP_ANDN: ALUResult = A & ~B;
            OP_ORN:  ALUResult = A | ~B;
            OP_SUB:  ALUResult = sum;
            OP_SLTU: ALUResult = {{(WIDTH-1){1'b0}}, ~carry};
            default: ALUResult = '0;
        endcase
    end

    assign zero = ~|ALUResult;

    always_comb begin
        flags_d = flags_q;
        if (flag_en) begin
            flags_d.n = ALUResult[WIDTH-1];
            flags_d.z = zero;
            flags_d.c = is_arith & carry;
            flags_d.v = is_arith & ovf;
        end
    end

    // NOTE: non-blocking assignment for state; reset clears flags without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: a driver pushes model expectations into a
// queue after each rising edge; a monitor pops and compares on the falling edge.
module tb_mips_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_ctrl;
    logic        flag_en;
    logic [31:0] alu_result;
    logic        zero;
    logic        flag_n, flag_z, flag_c, flag_v;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [3:0]  flags;  // {n, z, c, v}
        string       tag;
    } item_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
    } model_t;

    item_t      sb_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] mflags = 4'b0000;

    mips_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (a),
        .B          (b),
        .ALUControl (alu_ctrl),
        .flag_en    (flag_en),
        .ALUResult  (alu_result),
        .zero       (zero),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_v     (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic model_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        model_t      m;
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      sres;
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        logic        c = 1'b0;
        logic        v = 1'b0;
        logic [31:0] r;
        case (op)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b100: r = x & ~y;
            3'b101: r = x | ~y;
            3'b010: begin
                r    = x + y;
                c    = (ux + uy) > 64'hFFFF_FFFF;
                sres = sx + sy;
                v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            default: begin
                c    = (ux >= uy);
                sres = sx - sy;
                v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
                if (op == 3'b110) r = x - y;
                else if (op == 3'b011) r = (sx < sy) ? 32'd1 : 32'd0;
                else r = (ux < uy) ? 32'd1 : 32'd0;
            end
        endcase
        m.res   = r;
        m.flags = {r[31], (r == 32'd0), c, v};
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus. has_exp supplies a hand-derived result instead of the model's.
    task automatic drive(input logic [31:0] na, input logic [31:0] nb, input logic [2:0] nop,
                         input logic nen, input logic nrst, input string tag,
                         input bit has_exp = 1'b0, input logic [31:0] exp_res = 32'd0);
        item_t  it;
        model_t m;
        @(posedge clk);
        #1;
        if (rst_n && flag_en) mflags = model(a, b, alu_ctrl).flags;
        a        = na;
        b        = nb;
        alu_ctrl = nop;
        flag_en  = nen;
        rst_n    = nrst;
        if (!nrst) mflags = 4'b0000;
        m        = model(na, nb, nop);
        it.res   = has_exp ? exp_res : m.res;
        it.zero  = (it.res == 32'd0);
        it.flags = mflags;
        it.tag   = tag;
        sb_q.push_back(it);
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                check({it.tag, ".result"}, alu_result, it.res);
                check({it.tag, ".zero"}, 32'(zero), 32'(it.zero));
                check({it.tag, ".flags"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(it.flags));
            end
        end
    end

    initial begin : driver
        logic [31:0] ra, rb;
        logic [31:0] corners[6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234};
        a = '0; b = '0; alu_ctrl = 3'b000; flag_en = 1'b0; rst_n = 1'b0;

        // Reset held with flag_en=1: reset wins.
        drive(32'h7FFF_FFFF, 32'h1, 3'b010, 1'b1, 1'b0, "rst0");
        drive(32'h7FFF_FFFF, 32'h1, 3'b010, 1'b1, 1'b0, "rst1");

        drive(5, 10, 3'b000, 1'b1, 1'b1, "p5_and", 1'b1, 32'd0);
        drive(5, 10, 3'b001, 1'b1, 1'b1, "p5_or",  1'b1, 32'd15);
        drive(5, 10, 3'b010, 1'b1, 1'b1, "p5_add", 1'b1, 32'd15);
        drive(5, 10, 3'b110, 1'b1, 1'b1, "p5_sub", 1'b1, 32'hFFFF_FFFB);
        drive(5, 10, 3'b111, 1'b1, 1'b1, "p5_sltu", 1'b1, 32'd1);

        drive(25, 32'hFFFF_FFF1, 3'b000, 1'b1, 1'b1, "p25_and", 1'b1, 32'h11);
        drive(25, 32'hFFFF_FFF1, 3'b001, 1'b1, 1'b1, "p25_or",  1'b1, 32'hFFFF_FFF9);
        drive(25, 32'hFFFF_FFF1, 3'b010, 1'b1, 1'b1, "p25_add", 1'b1, 32'd10);
        drive(25, 32'hFFFF_FFF1, 3'b110, 1'b1, 1'b1, "p25_sub", 1'b1, 32'd40);
        drive(25, 32'hFFFF_FFF1, 3'b111, 1'b1, 1'b1, "p25_sltu", 1'b1, 32'd1);
        drive(25, 32'hFFFF_FFF1, 3'b011, 1'b1, 1'b1, "p25_slt", 1'b1, 32'd0);

        drive(32'h7FFF_FFFF, 1, 3'b010, 1'b1, 1'b1, "ovf_add", 1'b1, 32'h8000_0000);
        drive(32'h8000_0000, 1, 3'b011, 1'b1, 1'b1, "ovf_slt", 1'b1, 32'd1);
        drive(32'h8000_0000, 1, 3'b111, 1'b1, 1'b1, "ovf_sltu", 1'b1, 32'd0);
        drive(32'h1234, 32'h1234, 3'b110, 1'b1, 1'b1, "eq_sub", 1'b1, 32'd0);
        drive(32'h7FFF_FFFF, 1, 3'b010, 1'b0, 1'b1, "eq_flags", 1'b1, 32'h8000_0000);

        // Load nonzero flags, hold them, then clear asynchronously and reload.
        drive(32'h7FFF_FFFF, 1, 3'b010, 1'b1, 1'b1, "load");
        drive(3, 3, 3'b110, 1'b0, 1'b1, "hold0");
        drive(9, 2, 3'b001, 1'b0, 1'b1, "hold1");
        drive(9, 2, 3'b101, 1'b0, 1'b1, "hold2");
        drive(6, 7, 3'b100, 1'b1, 1'b0, "arst0", 1'b1, 32'd0);
        drive(6, 7, 3'b010, 1'b1, 1'b0, "arst1", 1'b1, 32'd13);
        drive(32'h8000_0000, 32'h8000_0000, 3'b010, 1'b1, 1'b1, "rel");
        drive(1, 2, 3'b000, 1'b0, 1'b1, "reload");

        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            drive(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) != 0), "rand");
        end

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
